fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the pipelined MIPS core.
- Owns the PC, drives the combinational instruction memory address, and loads the IF/ID pipeline register.
- Applies hazard stalls and ID-stage branch/jump redirects, inserting a flush bubble on each redirect.
- Detects out-of-range or misaligned fetches and freezes the front end; keeps fetch and flush counters for debug.

---
 rtl/fetch_ctrl.sv | 132 +++++++++++++
 tb/tb_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, addresses instruction memory,
// loads the IF/ID register, applies stalls and ID-stage redirects, and
// freezes the front end on an out-of-range or misaligned fetch.
//
// state | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetch; stall > branch > jump > sequential advance
// FAULT | front end frozen after a bad fetch; exits only through reset
module fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          IM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic [31:0] im_instr,
    output logic [31:0] im_addr,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count,
    output logic [15:0] flush_count
);

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam logic [29:0] IM_LIMIT = 30'(IM_DEPTH);

    state_t      state;
    state_t      state_nxt;

    logic        bad;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;

    logic [31:0] pc_nxt;
    logic [31:0] ifid_instr_nxt;
    logic [31:0] ifid_pc4_nxt;
    logic        ifid_valid_nxt;
    logic        fetch_fault_nxt;
    logic [31:0] fetch_count_nxt;
    logic [15:0] flush_count_nxt;

    assign im_addr     = pc;
    assign bad         = (pc[1:0] != 2'b00) || (pc[31:2] >= IM_LIMIT);
    assign pc_plus4    = pc + 32'd4;
    // The j upper nibble comes from the PC+4 of the jump itself, held in IF/ID.
    assign jump_target = {ifid_pc4[31:28], jump_index, 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: a bad PC seen in RUN freezes the front end.
    always_comb begin
        state_nxt = state;
        if (state == RUN && bad) begin
            state_nxt = FAULT;
        end
    end

    // Next values for PC, IF/ID and counters by RUN-state priority.
    always_comb begin
        pc_nxt          = pc;
        ifid_instr_nxt  = ifid_instr;
        ifid_pc4_nxt    = ifid_pc4;
        ifid_valid_nxt  = ifid_valid;
        fetch_fault_nxt = fetch_fault;
        fetch_count_nxt = fetch_count;
        flush_count_nxt = flush_count;
        if (state == RUN) begin
            if (bad) begin
                // The bad fetch is dropped; pc4 and counters keep their values.
                fetch_fault_nxt = 1'b1;
                ifid_valid_nxt  = 1'b0;
                ifid_instr_nxt  = 32'd0;
            end else if (stall) begin
                // Redirect operands are not final while stalled; hold everything.
            end else if (branch_taken || jump) begin
                pc_nxt         = branch_taken ? branch_target : jump_target;
                ifid_instr_nxt = 32'd0;
                ifid_pc4_nxt   = 32'd0;
                ifid_valid_nxt = 1'b0;
                if (flush_count != 16'hFFFF) begin
                    flush_count_nxt = flush_count + 16'd1;
                end
            end else begin
                pc_nxt          = pc_plus4;
                ifid_instr_nxt  = im_instr;
                ifid_pc4_nxt    = pc_plus4;
                ifid_valid_nxt  = 1'b1;
                fetch_count_nxt = fetch_count + 32'd1;
            end
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= PC_RESET;
            ifid_instr  <= 32'd0;
            ifid_pc4    <= 32'd0;
            ifid_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_count <= 32'd0;
            flush_count <= 16'd0;
        end else begin
            pc          <= pc_nxt;
            ifid_instr  <= ifid_instr_nxt;
            ifid_pc4    <= ifid_pc4_nxt;
            ifid_valid  <= ifid_valid_nxt;
            fetch_fault <= fetch_fault_nxt;
            fetch_count <= fetch_count_nxt;
            flush_count <= flush_count_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a vector table for the main sequence and a
// hand-written run for counter saturation and a high out-of-range redirect.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.PC_RESET(32'h0000_0000), .IM_DEPTH(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_index   (jump_index),
        .im_instr     (im_instr),
        .im_addr      (im_addr),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .fetch_fault  (fetch_fault),
        .fetch_count  (fetch_count),
        .flush_count  (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] w(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Instruction memory model: 64 words, garbage outside the legal range.
    always_comb begin
        if (im_addr[1:0] == 2'b00 && im_addr[31:2] < 30'd64) begin
            im_instr = w(int'(im_addr[7:2]));
        end else begin
            im_instr = 32'hDEAD_BEEF;
        end
    end

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        jmp;
        logic [25:0] jidx;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_fc;
        logic [15:0] e_fl;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic r, input logic s, input logic b,
                                input logic [31:0] t, input logic j, input logic [25:0] ji,
                                input logic [31:0] p, input logic [31:0] ins,
                                input logic [31:0] p4, input logic v, input logic f,
                                input logic [31:0] fc, input logic [15:0] fl);
        vec_t x;
        x.rst_n = r; x.stall = s; x.br = b; x.tgt = t; x.jmp = j; x.jidx = ji;
        x.e_pc = p; x.e_instr = ins; x.e_pc4 = p4; x.e_valid = v; x.e_fault = f;
        x.e_fc = fc; x.e_fl = fl;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                         input logic j, input logic [25:0] ji);
        @(negedge clk);
        rst_n = r; stall = s; branch_taken = b; branch_target = t; jump = j; jump_index = ji;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " pc"},          pc,                   v.e_pc);
        chk({tag, " im_addr"},     im_addr,              v.e_pc);
        chk({tag, " ifid_instr"},  ifid_instr,           v.e_instr);
        chk({tag, " ifid_pc4"},    ifid_pc4,             v.e_pc4);
        chk({tag, " ifid_valid"},  32'(ifid_valid),      32'(v.e_valid));
        chk({tag, " fetch_fault"}, 32'(fetch_fault),     32'(v.e_fault));
        chk({tag, " fetch_count"}, fetch_count,          v.e_fc);
        chk({tag, " flush_count"}, 32'(flush_count),     32'(v.e_fl));
    endtask

    initial begin
        vec_t hv;
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        jump = 1'b0; jump_index = 26'd0;

        //             rst  stl br  tgt           j   jidx    pc            instr     pc4           v  f  fc  fl
        vecs[0]  = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h00,       32'h0,    32'h00,       0,0, 0, 0);
        vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h04,       w(0),     32'h04,       1,0, 1, 0);
        vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h08,       w(1),     32'h08,       1,0, 2, 0);
        vecs[3]  = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,26'd0, 32'h08,       w(1),     32'h08,       1,0, 2, 0);
        vecs[4]  = mk(1'b1,1'b1,1'b1,32'h40,      1'b1,26'd3, 32'h08,       w(1),     32'h08,       1,0, 2, 0);
        vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h0C,       w(2),     32'h0C,       1,0, 3, 0);
        vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h10,       w(3),     32'h10,       1,0, 4, 0);
        vecs[7]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h14,       w(4),     32'h14,       1,0, 5, 0);
        vecs[8]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h18,       w(5),     32'h18,       1,0, 6, 0);
        vecs[9]  = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h1C,       w(6),     32'h1C,       1,0, 7, 0);
        vecs[10] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h20,       w(7),     32'h20,       1,0, 8, 0);
        vecs[11] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h24,       w(8),     32'h24,       1,0, 9, 0);
        vecs[12] = mk(1'b1,1'b0,1'b1,32'h48,      1'b0,26'd0, 32'h48,       32'h0,    32'h00,       0,0, 9, 1);
        vecs[13] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h4C,       w(18),    32'h4C,       1,0,10, 1);
        vecs[14] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,26'd14,32'h38,       32'h0,    32'h00,       0,0,10, 2);
        vecs[15] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h3C,       w(14),    32'h3C,       1,0,11, 2);
        vecs[16] = mk(1'b1,1'b0,1'b1,32'h3C,      1'b1,26'd5, 32'h3C,       32'h0,    32'h00,       0,0,11, 3);
        vecs[17] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h40,       w(15),    32'h40,       1,0,12, 3);
        vecs[18] = mk(1'b1,1'b0,1'b1,32'hF8,      1'b0,26'd0, 32'hF8,       32'h0,    32'h00,       0,0,12, 4);
        vecs[19] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'hFC,       w(62),    32'hFC,       1,0,13, 4);
        vecs[20] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h100,      w(63),    32'h100,      1,0,14, 4);
        vecs[21] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h100,      32'h0,    32'h100,      0,1,14, 4);
        vecs[22] = mk(1'b1,1'b1,1'b0,32'h0,       1'b0,26'd0, 32'h100,      32'h0,    32'h100,      0,1,14, 4);
        vecs[23] = mk(1'b1,1'b0,1'b1,32'h0,       1'b0,26'd0, 32'h100,      32'h0,    32'h100,      0,1,14, 4);
        vecs[24] = mk(1'b1,1'b0,1'b0,32'h0,       1'b1,26'd1, 32'h100,      32'h0,    32'h100,      0,1,14, 4);
        vecs[25] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h00,       32'h0,    32'h00,       0,0, 0, 0);
        vecs[26] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h04,       w(0),     32'h04,       1,0, 1, 0);
        vecs[27] = mk(1'b1,1'b0,1'b1,32'h6,       1'b0,26'd0, 32'h06,       32'h0,    32'h00,       0,0, 1, 1);
        vecs[28] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h06,       32'h0,    32'h00,       0,1, 1, 1);
        vecs[29] = mk(1'b0,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h00,       32'h0,    32'h00,       0,0, 0, 0);
        vecs[30] = mk(1'b1,1'b0,1'b0,32'h0,       1'b0,26'd0, 32'h04,       w(0),     32'h04,       1,0, 1, 0);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].jmp, vecs[i].jidx);
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Flush counter saturation: branch to 0 every cycle (pc stays legal).
        for (int i = 0; i < 65535; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 26'd0);
        end
        hv = mk(1'b1,1'b0,1'b1,32'h0,1'b0,26'd0, 32'h0, 32'h0, 32'h0, 0,0, 1, 16'hFFFF);
        check_all("sat_reach", hv);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 26'd0);
        check_all("sat_hold", hv);

        // Aligned but far out-of-range redirect: loaded first, fault next edge.
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 26'd0);
        hv = mk(1'b1,1'b0,1'b0,32'h0,1'b0,26'd0, 32'h8000_0000, 32'h0, 32'h0, 0,0, 1, 16'hFFFF);
        check_all("hi_load", hv);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 26'd0);
        hv.e_fault = 1'b1;
        check_all("hi_fault", hv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
